// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 0-F driver for a DIGITS-wide 7-segment display.
// Displays shadowed data with leading-zero suppression and one dead-time cycle per digit slot.
module seven_seg_scanner #(
    parameter int DIGITS         = 4,
    parameter int DIV            = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            segments,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     digit_en
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_INV  = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_INV  = {DIGITS{DIG_ACTIVE_LOW}};

    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;

    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_dark;
    logic                zero_run;
    logic [DIGITS-1:0]   en_hot;
    logic [6:0]          seg_logical;

    // Active-high segment pattern, [6]=a .. [0]=g.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down so zero_run means "this nibble and
    // everything above it is zero" when the selected digit is reached.
    // NOTE: zero_run is a blocking scratch variable carried across loop iterations;
    // every comb output gets a default first so no latch is inferred.
    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        zero_run = 1'b1;
        en_hot   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (sh_val[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == idx) begin
                en_hot[i] = 1'b1;
                cur_nib   = sh_val[4*i +: 4];
                cur_dp    = sh_dp[i];
                cur_dark  = sh_blank[i] || (LZ_BLANK && (i != 0) && zero_run);
            end
        end
        seg_logical = cur_dark ? 7'h00 : decode(cur_nib);
    end

    // NOTE: the design has no memory arrays, so every register, shadow data included,
    // is cleared by reset and the display comes up dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_val   <= '0;
            sh_dp    <= '0;
            sh_blank <= '0;
            cnt      <= '0;
            idx      <= '0;
            segments <= SEG_INV;
            dp_out   <= SEG_ACTIVE_LOW;
            digit_en <= DIG_INV;
        end else begin
            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp;
                sh_blank <= blank;
            end

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            segments <= seg_logical ^ SEG_INV;
            dp_out   <= (cur_dp && !cur_dark) ^ SEG_ACTIVE_LOW;
            // First cycle of each slot keeps every digit off to avoid ghosting.
            digit_en <= ((cnt == '0) ? '0 : en_hot) ^ DIG_INV;
        end
    end

endmodule
